// File: rtl/memory_responder.sv
// Single-port memory shared by a CPU bus and a program-load burst engine.
// Define MEM_WP_EN to discard CPU writes to 0x00-0x7F and flag them on wp_err.
module memory_responder #(
    parameter int word_size = 8,
    parameter int mem_depth = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Load_Add_R,
    input  logic [word_size-1:0] bus2_addr,
    input  logic                 write,
    input  logic [word_size-1:0] bus1_data,
    output logic [word_size-1:0] mem_word,
    input  logic                 ld_start,
    input  logic [word_size-1:0] ld_len,
    input  logic                 ld_valid,
    input  logic [word_size-1:0] ld_data,
    output logic                 ld_ready,
    output logic                 cpu_hold,
    output logic                 ld_done,
    output logic                 wp_err
);

    localparam int AW  = (mem_depth > 1) ? $clog2(mem_depth) : 1;
    localparam int CLW = $clog2(mem_depth + 1);
    localparam int CW  = (CLW > word_size) ? CLW : word_size;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t               state, state_nxt;
    logic [word_size-1:0] mem [mem_depth];
    logic [word_size-1:0] addr_reg;
    logic [AW-1:0]        ptr;
    logic [AW-1:0]        cpu_idx;
    logic [CW-1:0]        cnt;
    logic                 accept;
    logic                 last;
    logic                 cpu_we;
    logic                 wp_hit;

    function automatic logic [AW-1:0] wrap_addr(input logic [word_size-1:0] a);
        logic [31:0] t;
        t = 32'(a) % 32'(mem_depth);
        return t[AW-1:0];
    endfunction

    assign cpu_idx  = wrap_addr(addr_reg);
    assign mem_word = mem[cpu_idx];

    assign ld_ready = (state == LOAD);
    assign ld_done  = (state == DONE);
    assign cpu_hold = (state != IDLE);
    assign accept   = (state == LOAD) && ld_valid;
    assign last     = (cnt == CW'(1));

`ifdef MEM_WP_EN
    assign wp_hit = (32'(cpu_idx) < 32'h80);
`else
    assign wp_hit = 1'b0;
`endif

    // Gating on rst keeps a CPU write from landing while reset is held.
    assign cpu_we = rst && !cpu_hold && write && !wp_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ld_start) state_nxt = LOAD;
            LOAD:    if (accept && last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A zero length means a full-memory burst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
            cnt <= '0;
        end else if (state == IDLE && ld_start) begin
            ptr <= '0;
            cnt <= (ld_len == '0) ? CW'(mem_depth) : CW'(ld_len);
        end else if (accept) begin
            ptr <= (ptr == AW'(mem_depth - 1)) ? '0 : ptr + AW'(1);
            cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       addr_reg <= '0;
        else if (!cpu_hold && Load_Add_R) addr_reg <= bus2_addr;
    end

    // Storage has no reset; loader and CPU are mutually exclusive via cpu_hold.
    always_ff @(posedge clk) begin
        if (accept)      mem[ptr]     <= ld_data;
        else if (cpu_we) mem[cpu_idx] <= bus1_data;
    end

`ifdef MEM_WP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                     wp_err <= 1'b0;
        else if (!cpu_hold && write && wp_hit)        wp_err <= 1'b1;
    end
`else
    assign wp_err = 1'b0;
`endif

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: load bursts, CPU access, reset abort, write protect.
module tb_memory_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       Load_Add_R, write, ld_start, ld_valid;
    logic [7:0] bus2_addr, bus1_data, ld_len, ld_data;
    logic [7:0] mem_word;
    logic       ld_ready, cpu_hold, ld_done, wp_err;

    int checks = 0;
    int errors = 0;
    int hold_cyc = 0;
    int done_cnt = 0;
    int h0, d0;

    memory_responder #(.word_size(8), .mem_depth(256)) dut (
        .clk(clk), .rst(rst),
        .Load_Add_R(Load_Add_R), .bus2_addr(bus2_addr),
        .write(write), .bus1_data(bus1_data), .mem_word(mem_word),
        .ld_start(ld_start), .ld_len(ld_len), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .cpu_hold(cpu_hold), .ld_done(ld_done), .wp_err(wp_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cpu_hold) hold_cyc++;
        if (ld_done)  done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
        Load_Add_R = 1'b1;
        bus2_addr  = a;
        tick();
        Load_Add_R = 1'b0;
        chk(tag, {24'd0, mem_word}, {24'd0, exp});
    endtask

    task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
        Load_Add_R = 1'b1;
        bus2_addr  = a;
        tick();
        Load_Add_R = 1'b0;
        write      = 1'b1;
        bus1_data  = d;
        tick();
        write      = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        Load_Add_R = 1'b0; write = 1'b0; ld_start = 1'b0; ld_valid = 1'b0;
        bus2_addr = 8'h00; bus1_data = 8'h00; ld_len = 8'h00; ld_data = 8'h00;
        #12;
        chk("rst_hold",  {31'd0, cpu_hold}, 32'd0);
        chk("rst_ready", {31'd0, ld_ready}, 32'd0);
        chk("rst_done",  {31'd0, ld_done},  32'd0);
        chk("rst_wp",    {31'd0, wp_err},   32'd0);
        rst = 1'b1;
        tick();

        // Three-byte burst, valid held high
        h0 = hold_cyc; d0 = done_cnt;
        ld_start = 1'b1; ld_len = 8'd3;
        tick();
        ld_start = 1'b0;
        chk("b1_ready", {31'd0, ld_ready}, 32'd1);
        ld_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ld_data = 8'h51 + 8'(k);
            tick();
        end
        ld_valid = 1'b0;
        chk("b1_done_pulse", {31'd0, ld_done}, 32'd1);
        tick();
        chk("b1_idle_hold", {31'd0, cpu_hold}, 32'd0);
        tick(); tick();
        chk("b1_hold_cycles", 32'(hold_cyc - h0), 32'd4);
        chk("b1_done_count",  32'(done_cnt - d0), 32'd1);
        rd(8'h00, 8'h51, "b1_mem0");
        rd(8'h01, 8'h52, "b1_mem1");
        rd(8'h02, 8'h53, "b1_mem2");

        // Throttled burst; ld_start during LOAD must not reload the counter
        ld_start = 1'b1; ld_len = 8'd2;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 8'h61;
        tick();
        ld_valid = 1'b0; ld_data = 8'hEE; ld_start = 1'b1; ld_len = 8'd7;
        tick();
        ld_start = 1'b0;
        chk("b2_gap_ready", {31'd0, ld_ready}, 32'd1);
        chk("b2_gap_done",  {31'd0, ld_done},  32'd0);
        ld_valid = 1'b1; ld_data = 8'h62;
        tick();
        ld_valid = 1'b0;
        chk("b2_done", {31'd0, ld_done}, 32'd1);
        tick();
        rd(8'h01, 8'h62, "b2_mem1");
        rd(8'h02, 8'h53, "b2_mem2");

        // CPU write then read back
        cpu_wr(8'h90, 8'hA5);
        chk("cpu_rd_90", {24'd0, mem_word}, 32'h000000A5);

        // Same-cycle address load and write
        cpu_wr(8'h91, 8'h77);
        Load_Add_R = 1'b1; bus2_addr = 8'h90;
        tick();
        Load_Add_R = 1'b1; bus2_addr = 8'h91; write = 1'b1; bus1_data = 8'h3C;
        tick();
        Load_Add_R = 1'b0; write = 1'b0;
        chk("same_91_unchanged", {24'd0, mem_word}, 32'h00000077);
        rd(8'h90, 8'h3C, "same_90_written");

        // CPU strobes ignored while held
        ld_start = 1'b1; ld_len = 8'd1;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 8'h71;
        Load_Add_R = 1'b1; bus2_addr = 8'h20; write = 1'b1; bus1_data = 8'hDD;
        tick();
        ld_valid = 1'b0;
        tick();
        Load_Add_R = 1'b0; write = 1'b0;
        chk("hold_ignores_cpu", {24'd0, mem_word}, 32'h0000003C);

        // Reset after 2 of 5 bytes
        d0 = done_cnt;
        ld_start = 1'b1; ld_len = 8'd5;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1;
        ld_data = 8'h81; tick();
        ld_data = 8'h82; tick();
        ld_data = 8'h83;
        rst = 1'b0;
        #1;
        chk("abort_hold",  {31'd0, cpu_hold}, 32'd0);
        chk("abort_ready", {31'd0, ld_ready}, 32'd0);
        tick();
        rst = 1'b1; ld_valid = 1'b0;
        tick(); tick(); tick();
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        rd(8'h00, 8'h81, "abort_mem0");
        rd(8'h01, 8'h82, "abort_mem1");
        rd(8'h02, 8'h53, "abort_mem2");

        // Full-depth burst (length 0): data is address ^ 0x5A
        ld_start = 1'b1; ld_len = 8'd0;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1;
        for (int k = 0; k < 255; k++) begin
            ld_data = 8'(k) ^ 8'h5A;
            tick();
        end
        chk("full_255_not_done", {31'd0, ld_done}, 32'd0);
        chk("full_255_ready",    {31'd0, ld_ready}, 32'd1);
        ld_data = 8'hFF ^ 8'h5A;
        tick();
        ld_valid = 1'b0;
        chk("full_256_done", {31'd0, ld_done}, 32'd1);
        tick();
        rd(8'hFF, 8'hA5, "full_memFF");
        rd(8'h10, 8'h4A, "full_mem10");

        // CPU write into the low half
        cpu_wr(8'h10, 8'hFF);
`ifdef MEM_WP_EN
        chk("wp_mem10", {24'd0, mem_word}, 32'h0000004A);
        chk("wp_err",   {31'd0, wp_err},   32'd1);
`else
        chk("wp_mem10", {24'd0, mem_word}, 32'h000000FF);
        chk("wp_err",   {31'd0, wp_err},   32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter word_size, default 8, giving the data and address width in bits.
REQ-002 SHALL have parameter mem_depth, default 256, giving the number of storage words, addressed 0..mem_depth-1.
REQ-003 SHALL have port clk  in  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Load_Add_R  in  1  CPU strobe to load the address register from bus2_addr.
REQ-006 SHALL have port bus2_addr  in  word_size  CPU Bus_2 value used as the address.
REQ-007 SHALL have port write  in  1  CPU write strobe.
REQ-008 SHALL have port bus1_data  in  word_size  CPU Bus_1 value used as the write data.
REQ-009 SHALL have port mem_word  out  word_size  word read from the current address.
REQ-010 SHALL have port ld_start  in  1  request to start a program-load burst.
REQ-011 SHALL have port ld_len  in  word_size  burst length in bytes; 0 means mem_depth.
REQ-012 SHALL have port ld_valid  in  1  loader byte valid.
REQ-013 SHALL have port ld_data  in  word_size  loader byte.
REQ-014 SHALL have port ld_ready  out  1  responder accepts a loader byte.
REQ-015 SHALL have port cpu_hold  out  1  holds the CPU off; wired to the CPU's rst through an inverter.
REQ-016 SHALL have port ld_done  out  1  one-cycle pulse when a load burst completes.
REQ-017 SHALL have port wp_err  out  1  sticky write-protect violation flag (see Configuration).

Function
REQ-018 SHALL implement the FSM states IDLE, LOAD and DONE.
REQ-019 In IDLE, ld_start=1 SHALL capture ld_len into the byte counter, clear the load pointer to 0 and move to LOAD on the next edge.
REQ-020 In LOAD, ld_ready SHALL be 1, and each cycle with ld_valid=1 SHALL write ld_data to mem[load pointer], increment the pointer and decrement the counter.
REQ-021 When the final byte is accepted, the FSM SHALL go to DONE; a byte count of 0 SHALL transfer mem_depth bytes, with the pointer wrapping from mem_depth-1 to 0.
REQ-022 DONE SHALL last exactly 1 cycle with ld_done=1, then the FSM SHALL return to IDLE.
REQ-023 cpu_hold SHALL be 1 in LOAD and DONE and 0 in IDLE, with no added latency (decoded from state).
REQ-024 ld_start SHALL be ignored outside IDLE.
REQ-025 With cpu_hold=0, Load_Add_R=1 SHALL load addr_reg with bus2_addr at the clock edge.
REQ-026 With cpu_hold=0, write=1 SHALL store bus1_data to mem[addr_reg] at the clock edge.
REQ-027 If Load_Add_R and write are both 1 in one cycle, the write SHALL use the old addr_reg value and addr_reg SHALL then take the new address.
REQ-028 With cpu_hold=1, Load_Add_R and write SHALL be ignored.
REQ-029 mem_word SHALL equal mem[addr_reg] combinationally; after a write, the new data SHALL appear from the following cycle.
REQ-030 Addresses SHALL be taken modulo mem_depth.
REQ-031 The loader and the CPU SHALL never write in the same cycle, because cpu_hold gates the CPU.

Reset
REQ-032 rst=0 SHALL immediately force state=IDLE, addr_reg=0, load pointer=0, counter=0, ld_ready=0, ld_done=0, cpu_hold=0 and wp_err=0.
REQ-033 Memory contents SHALL NOT be cleared by reset.
REQ-034 A reset during LOAD SHALL abort the burst; bytes already written SHALL be retained and no ld_done pulse SHALL be produced.

Configuration
REQ-035 Macro MEM_WP_EN SHALL control the write-protect feature.
REQ-036 With MEM_WP_EN defined, CPU writes to addresses 0x00-0x7F SHALL be discarded and SHALL set wp_err=1.
REQ-037 With MEM_WP_EN defined, wp_err SHALL clear only on reset; loader writes SHALL never be protected.
REQ-038 Without MEM_WP_EN, all CPU writes SHALL succeed and wp_err SHALL be tied to 0.

Verification
REQ-039 Load burst: ld_start, ld_len=3, bytes 0x51,0x52,0x53 with ld_valid held high -> cpu_hold=1 for 4 cycles; ld_done pulses once; mem[0..2]=0x51,0x52,0x53.
REQ-040 Throttled load: ld_valid toggled 1/0 with ld_len=2 -> only valid cycles are counted; DONE is reached after the 2nd accepted byte.
REQ-041 CPU access: Load_Add_R with bus2_addr=0x90, then write with bus1_data=0xA5 -> mem_word=0xA5 on the following cycle.
REQ-042 Same-cycle case: addr_reg=0x90, then Load_Add_R (bus2_addr=0x91) and write (bus1_data=0x3C) together -> mem[0x90]=0x3C, mem[0x91] unchanged, addr_reg=0x91.
REQ-043 Reset mid-burst: rst=0 after 2 of 5 bytes are accepted -> state IDLE, cpu_hold=0, no ld_done, mem[0..1] retained.
REQ-044 MEM_WP_EN: CPU write of 0xFF to 0x10 -> mem[0x10] unchanged and wp_err=1; without the macro -> mem[0x10]=0xFF and wp_err=0.
